// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter.
//   - Digit constants used by the reverse double-dabble adjust step
//   - FSM state encoding
//   - Helper functions for counter sizing
package bcd_pkg;

    localparam int       DIGIT_W    = 4;
    localparam logic [3:0] MAX_DIGIT  = 4'd9;
    localparam logic [3:0] ADJ_THRESH = 4'd8;
    localparam logic [3:0] ADJ_SUB    = 4'd3;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Ceiling log2 with a constant loop bound so it elaborates as a constant.
    function automatic int clog2(input int unsigned value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    // The bit counter must hold values 0 .. 4*digits.
    function automatic int cnt_width(input int unsigned digits);
        return clog2(4 * digits + 1);
    endfunction

endpackage

// File: rtl/bcd_to_bin_seq_digit_adj.sv
// bcd_digit_adj: combinational adjust of one BCD digit for reverse
// double-dabble. A shifted digit of 8 or more received a carried-in half
// of 10 (i.e. 5 becoming 8), so 3 is removed to restore a valid digit.
// Ports:
//   d_in  - 4-bit digit after the right shift
//   d_out - adjusted digit
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] d_in,
    output logic [3:0] d_out
);

    // Subtract 3 from digits at or above the threshold.
    always_comb begin
        if (d_in >= ADJ_THRESH) begin
            d_out = d_in - ADJ_SUB;
        end else begin
            d_out = d_in;
        end
    end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: sequential BCD-to-binary converter (reverse double-dabble).
// One shift per clock; 4*DIGITS clocks per conversion, START/BUSY/DONE
// handshake.
// Ports:
//   CLK     - rising-edge clock
//   RST_N   - asynchronous active-low reset
//   START   - conversion request, sampled only while idle
//   BCD_IN  - packed BCD, digit 0 in [3:0], sampled on the accepting edge
//   BIN_OUT - registered binary result, held until the next completion
//   BUSY    - conversion in progress
//   DONE    - one-cycle pulse when BIN_OUT/ERR update
//   ERR     - last accepted input had a digit > 9 (only with BCD_CHECK_EN)
// Configuration macro: BCD_CHECK_EN enables the invalid-digit check with a
// one-cycle error completion; without it ERR is tied low.
module bcd_to_bin_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  START,
    input  logic [4*DIGITS-1:0]   BCD_IN,
    output logic [BIN_W-1:0]      BIN_OUT,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERR
);

    localparam int FW    = DIGIT_W * DIGITS;
    localparam int SR_W  = 2 * FW;
    localparam int CNT_W = cnt_width(DIGITS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FW - 1);

    state_e             state_q, state_d;
    logic [SR_W-1:0]    sr_q, sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [SR_W-1:0]    shifted_s;
    logic [FW-1:0]      adj_bcd_s;
    logic [SR_W-1:0]    shift_next_s;

    // Whole register {bcd field, bin field} moves right by one each step.
    always_comb begin
        shifted_s = sr_q >> 1;
    end

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adj u_adj (
                .d_in  (shifted_s[FW + g*DIGIT_W +: DIGIT_W]),
                .d_out (adj_bcd_s[g*DIGIT_W +: DIGIT_W])
            );
        end
    endgenerate

    // Recombine adjusted bcd digits with the untouched bin field.
    always_comb begin
        shift_next_s = {adj_bcd_s, shifted_s[FW-1:0]};
    end

`ifdef BCD_CHECK_EN
    logic err_q, err_d;
    logic digit_bad_s;

    // Flag any input digit above 9.
    always_comb begin
        digit_bad_s = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (BCD_IN[i*DIGIT_W +: DIGIT_W] > MAX_DIGIT) begin
                digit_bad_s = 1'b1;
            end else begin
                digit_bad_s = digit_bad_s;
            end
        end
    end
`endif

    // Next-state and datapath control for the IDLE/SHIFT sequencer.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef BCD_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (START) begin
`ifdef BCD_CHECK_EN
                    if (digit_bad_s) begin
                        // Invalid input completes at once without shifting.
                        err_d   = 1'b1;
                        bin_d   = {BIN_W{1'b0}};
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        err_d   = 1'b0;
                        sr_d    = {BCD_IN, {FW{1'b0}}};
                        cnt_d   = {CNT_W{1'b0}};
                        busy_d  = 1'b1;
                        state_d = SHIFT;
                    end
`else
                    sr_d    = {BCD_IN, {FW{1'b0}}};
                    cnt_d   = {CNT_W{1'b0}};
                    busy_d  = 1'b1;
                    state_d = SHIFT;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                sr_d  = shift_next_s;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    // Final shift: bcd field is now empty, bin field holds the value.
                    bin_d   = shift_next_s[BIN_W-1:0];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = SHIFT;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Sequencer and datapath registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            sr_q    <= {SR_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            bin_q   <= {BIN_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef BCD_CHECK_EN
    // Sticky error flag, cleared by the next accepted valid request.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

    assign BIN_OUT = bin_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Scoreboard testbench for bcd_to_bin_seq (DIGITS=3, BIN_W=10).
module tb_bcd_to_bin_seq;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        START = 1'b0;
    logic [11:0] BCD_IN = 12'h000;
    logic [9:0]  BIN_OUT;
    logic        BUSY;
    logic        DONE;
    logic        ERR;

    typedef struct {
        logic [9:0] bin;
        logic       err;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;
    int   cyc = 0;

    bcd_to_bin_seq #(.DIGITS(3), .BIN_W(10)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .START   (START),
        .BCD_IN  (BCD_IN),
        .BIN_OUT (BIN_OUT),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .ERR     (ERR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        logic [3:0] h, t, o;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    // Monitor: pops the scoreboard on every DONE pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RST_N && DONE) begin
                done_cnt++;
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=%0d required=none", BIN_OUT);
                end else begin
                    e = sb_q.pop_front();
                    check("bin_out", int'(BIN_OUT), int'(e.bin));
                    check("err", int'(ERR), int'(e.err));
                end
            end
        end
    end

    task automatic push_exp(input int bin, input logic err);
        exp_t e;
        e.bin = 10'(bin);
        e.err = err;
        sb_q.push_back(e);
    endtask

    // Drive START for one accepting edge; returns just after that edge.
    task automatic start_conv(input logic [11:0] bcd);
        @(negedge CLK);
        BCD_IN = bcd;
        START  = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
    endtask

    // Counts edges after acceptance until DONE; checks BUSY stays high meanwhile.
    task automatic wait_done(output int edges, output bit busy_ok);
        bit seen;
        edges   = 0;
        busy_ok = 1'b1;
        seen    = 1'b0;
        while (!seen && edges < 64) begin
            @(negedge CLK);
            if (DONE) begin
                seen = 1'b1;
            end else begin
                if (!BUSY) busy_ok = 1'b0;
                @(posedge CLK);
                edges++;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=%0d required=<64", edges);
        end
    endtask

    initial begin
        int          edges;
        bit          busy_ok;
        int          d0;
        int          c_first;
        int          c_last;
        bit          timeout;
        logic [11:0] tbl_bcd [4];
        int          tbl_bin [4];

        // 1. reset state
        #23;
        RST_N = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            check("rst_bin", int'(BIN_OUT), 0);
            check("rst_busy", int'(BUSY), 0);
            check("rst_done", int'(DONE), 0);
            check("rst_err", int'(ERR), 0);
        end

        // 2. 999 with latency and BUSY profile
        push_exp(999, 1'b0);
        start_conv(12'h999);
        wait_done(edges, busy_ok);
        check("latency_999", edges, 12);
        check("busy_during_999", int'(busy_ok), 1);
        check("busy_at_done", int'(BUSY), 0);
        @(negedge CLK);
        check("done_one_cycle", int'(DONE), 0);

        // 3. boundary values
        tbl_bcd[0] = 12'h000; tbl_bin[0] = 0;
        tbl_bcd[1] = 12'h018; tbl_bin[1] = 18;
        tbl_bcd[2] = 12'h100; tbl_bin[2] = 100;
        tbl_bcd[3] = 12'h042; tbl_bin[3] = 42;
        for (int i = 0; i < 4; i++) begin
            push_exp(tbl_bin[i], 1'b0);
            start_conv(tbl_bcd[i]);
            wait_done(edges, busy_ok);
            check("latency_tbl", edges, 12);
        end

`ifdef BCD_CHECK_EN
        // 4. invalid digit then recovery
        push_exp(0, 1'b1);
        start_conv(12'h1A5);
        wait_done(edges, busy_ok);
        check("latency_err", edges, 0);
        push_exp(42, 1'b0);
        start_conv(12'h042);
        wait_done(edges, busy_ok);
        check("latency_after_err", edges, 12);
`endif

        // 5. START while busy is ignored
        repeat (2) @(negedge CLK);
        d0 = done_cnt;
        push_exp(250, 1'b0);
        start_conv(12'h250);
        repeat (3) @(negedge CLK);
        BCD_IN = 12'h777;
        START  = 1'b1;
        @(posedge CLK);
        #1;
        START  = 1'b0;
        BCD_IN = 12'h000;
        wait_done(edges, busy_ok);
        repeat (20) @(negedge CLK);
        check("busy_start_done_count", done_cnt - d0, 1);

        // 6. reset mid-conversion
        start_conv(12'h999);
        repeat (4) @(negedge CLK);
        d0 = done_cnt;
        RST_N = 1'b0;
        #1;
        check("abort_bin", int'(BIN_OUT), 0);
        check("abort_busy", int'(BUSY), 0);
        check("abort_done", int'(DONE), 0);
        check("abort_err", int'(ERR), 0);
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        repeat (20) @(negedge CLK);
        check("abort_no_done", done_cnt - d0, 0);
        push_exp(321, 1'b0);
        start_conv(12'h321);
        wait_done(edges, busy_ok);
        check("latency_321", edges, 12);

        // 7. sweep 0..999 with START held high
        repeat (2) @(negedge CLK);
        d0 = done_cnt;
        timeout = 1'b0;
        c_first = 0;
        c_last  = 0;
        BCD_IN = to_bcd(0);
        START  = 1'b1;
        push_exp(0, 1'b0);
        for (int v = 1; v <= 1000 && !timeout; v++) begin
            int n;
            n = 0;
            do begin
                @(negedge CLK);
                n++;
            end while (!DONE && n < 40);
            if (!DONE) begin
                timeout = 1'b1;
                START = 1'b0;
                checks++;
                failures++;
                $display("FAIL sweep_timeout actual=%0d required=<40", n);
            end else begin
                if (v == 1) c_first = cyc;
                if (v == 1000) begin
                    c_last = cyc;
                    START  = 1'b0;
                end else begin
                    BCD_IN = to_bcd(v);
                    push_exp(v, 1'b0);
                end
            end
        end
        repeat (20) @(negedge CLK);
        check("sweep_done_count", done_cnt - d0, 1000);
        check("sweep_spacing", c_last - c_first, 999 * 13);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
